// File: rtl/pe_iter.sv
// ---------------------------------------------------------------------------
// pe_iter : iterating priority encoder
//
// Captures a W-bit request vector and streams out the index of every set
// bit, one index per beat, over a valid/ready handshake. The priority order
// is chosen per vector: lowest index first, or highest index first. Each
// delivered bit is cleared from the pending set. When the final beat
// transfers, a new vector can be accepted in the same cycle, so
// back-to-back vectors stream with no idle cycle between them.
//
// Parameters
//   W             request vector width (any value >= 2)
//   IW            index width, derived from W
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   in            request vector
//   in_msb_first  priority mode captured with in (1 = highest index first)
//   in_valid      in / in_msb_first are valid
//   in_ready      block can accept a vector this cycle
//   out           index of the current highest-priority pending bit
//   out_cnt       number of pending bits, including the current one
//   out_last      current beat is the final bit of the vector
//   out_valid     out / out_cnt / out_last are valid
//   out_ready     consumer accepts the current beat
//   zero          one-cycle pulse after an all-zero vector is accepted
// ---------------------------------------------------------------------------
module pe_iter #(
  parameter int W  = 32,
  localparam int IW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in,
  input  logic          in_msb_first,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [IW-1:0] out,
  output logic [IW:0]   out_cnt,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          zero
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e         state_q;
  logic [W-1:0]   vec_q;
  logic           mode_q;
  logic           zero_q;

  logic [IW-1:0]  idx;
  logic [IW:0]    cnt;
  logic [W-1:0]   vec_d;
  logic           accept;
  logic           xfer;

  // Priority pick over the pending bits. The bit written last in the loop
  // wins, so scanning downward selects the lowest set bit and scanning
  // upward selects the highest. An empty vector yields index 0.
  always_comb begin
    idx = '0;
    if (mode_q) begin
      for (int i = 0; i < W; i++) begin
        if (vec_q[i]) idx = IW'(i);
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (vec_q[i]) idx = IW'(i);
      end
    end
  end

  // Population count of the pending bits.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + (IW + 1)'(vec_q[i]);
    end
  end

  assign out       = idx;
  assign out_cnt   = cnt;
  assign out_last  = (cnt == (IW + 1)'(1));
  assign out_valid = (state_q == SCAN);
  assign zero      = zero_q;

  // A new vector may enter while idle, or in the cycle in which the last
  // pending bit is handed over. Reset blocks acceptance outright.
  assign in_ready = !rst && ((state_q == IDLE) || (out_valid && out_ready && out_last));

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;

  // Pending set after the current beat is consumed: drop the delivered bit.
  assign vec_d = xfer ? (vec_q & ~(W'(1) << idx)) : vec_q;

  // Sequencer. The order of assignments matters: a vector accepted in the
  // same cycle as the final beat overrides the return to IDLE and the
  // clearing of the last bit, giving back-to-back streaming.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      mode_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      zero_q <= 1'b0;
      vec_q  <= vec_d;
      if (xfer && out_last) begin
        state_q <= IDLE;
      end
      if (accept) begin
        if (in != '0) begin
          vec_q   <= in;
          mode_q  <= in_msb_first;
          state_q <= SCAN;
        end else begin
          zero_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_iter.sv
// ---------------------------------------------------------------------------
// tb_pe_iter : directed testbench for pe_iter with W = 32
//
// Inputs are driven 1 time unit after each rising edge and outputs are
// compared 1 time unit later, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_pe_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in;
  logic        in_msb_first;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  out;
  logic [5:0]  out_cnt;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        zero;

  int assertCount = 0;
  int failCount   = 0;

  pe_iter #(.W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in),
    .in_msb_first (in_msb_first),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out          (out),
    .out_cnt      (out_cnt),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .zero         (zero)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive the producer and consumer side inputs.
  task automatic applyStimulus(input logic [31:0] vec, input logic msb,
                               input logic valid, input logic rdy);
    in           = vec;
    in_msb_first = msb;
    in_valid     = valid;
    out_ready    = rdy;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Check a full output beat.
  task automatic checkBeat(input string tag, input int idx, input int cnt,
                           input logic last);
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, ".out"},   32'(out),       32'(idx));
    checkOutput({tag, ".cnt"},   32'(out_cnt),   32'(cnt));
    checkOutput({tag, ".last"},  32'(out_last),  32'(last));
  endtask

  initial begin
    // Reset held for two cycles with in_valid asserted.
    rst = 1'b1;
    applyStimulus(32'h0000_0209, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 2; c++) begin
      cyc();
      #1;
      checkOutput("rst.in_ready",  32'(in_ready),  32'd0);
      checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst.out",       32'(out),       32'd0);
      checkOutput("rst.out_cnt",   32'(out_cnt),   32'd0);
      checkOutput("rst.out_last",  32'(out_last),  32'd0);
      checkOutput("rst.zero",      32'(zero),      32'd0);
    end
    cyc();
    rst = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("rel.in_ready", 32'(in_ready), 32'd1);

    // LSB-first walk of 0x209: indices 0, 3, 9.
    cyc();
    applyStimulus(32'h0000_0209, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("lsb.accept_rdy", 32'(in_ready), 32'd1);
    cyc();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    checkBeat("lsb0", 0, 3, 1'b0);
    checkOutput("lsb0.in_ready", 32'(in_ready), 32'd0);
    cyc();
    #1;
    checkBeat("lsb1", 3, 2, 1'b0);
    cyc();
    // Present the MSB-first vector during the last beat.
    applyStimulus(32'h0000_0209, 1'b1, 1'b1, 1'b1);
    #1;
    checkBeat("lsb2", 9, 1, 1'b1);
    checkOutput("lsb2.in_ready", 32'(in_ready), 32'd1);

    // MSB-first walk of 0x209: indices 9, 3, 0, with no bubble.
    cyc();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    checkBeat("msb0", 9, 3, 1'b0);
    cyc();
    #1;
    checkBeat("msb1", 3, 2, 1'b0);
    cyc();
    applyStimulus(32'h8000_0000, 1'b0, 1'b1, 1'b1);
    #1;
    checkBeat("msb2", 0, 1, 1'b1);
    checkOutput("msb2.in_ready", 32'(in_ready), 32'd1);
    cyc();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    checkBeat("b2b", 31, 1, 1'b1);
    cyc();
    #1;
    checkOutput("b2b.idle", 32'(out_valid), 32'd0);

    // Backpressure on 0x8000_0001.
    applyStimulus(32'h8000_0001, 1'b0, 1'b1, 1'b0);
    cyc();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkBeat("bp.hold", 0, 2, 1'b0);
      checkOutput("bp.in_ready", 32'(in_ready), 32'd0);
      cyc();
    end
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    checkBeat("bp0", 0, 2, 1'b0);
    cyc();
    #1;
    checkBeat("bp1", 31, 1, 1'b1);
    cyc();
    #1;
    checkOutput("bp.idle", 32'(out_valid), 32'd0);

    // All-zero vector is dropped with a single zero pulse.
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("zv.in_ready", 32'(in_ready), 32'd1);
    cyc();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("zv.pulse",     32'(zero),      32'd1);
    checkOutput("zv.out_valid", 32'(out_valid), 32'd0);
    checkOutput("zv.in_ready1", 32'(in_ready),  32'd1);
    cyc();
    #1;
    checkOutput("zv.pulse_end", 32'(zero),      32'd0);
    checkOutput("zv.in_ready2", 32'(in_ready),  32'd1);
    applyStimulus(32'h0000_0010, 1'b0, 1'b1, 1'b1);
    cyc();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    checkBeat("zv.next", 4, 1, 1'b1);
    cyc();
    #1;
    checkOutput("zv.idle", 32'(out_valid), 32'd0);

    // Reset in the middle of an all-ones vector.
    applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
    cyc();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    for (int b = 0; b < 5; b++) begin
      #1;
      checkBeat("ones", b, 32 - b, 1'b0);
      cyc();
    end
    rst = 1'b1;
    #1;
    checkOutput("mid.in_ready", 32'(in_ready), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    checkOutput("mid.out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid.out_cnt",   32'(out_cnt),   32'd0);
    checkOutput("mid.out",       32'(out),       32'd0);
    checkOutput("mid.in_ready1", 32'(in_ready),  32'd1);
    applyStimulus(32'h0000_0002, 1'b0, 1'b1, 1'b1);
    cyc();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    checkBeat("post", 1, 1, 1'b1);
    cyc();
    #1;
    checkOutput("post.idle", 32'(out_valid), 32'd0);
    checkOutput("post.cnt",  32'(out_cnt),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pe_iter.md
# pe_iter

Parametrised iterating priority encoder. It captures a W-bit request vector and emits the index of every set bit, one per beat, over a valid/ready stream. Priority order (LSB-first or MSB-first) is selectable per vector, and each delivered bit is cleared. It sits where the single-shot 32-bit priority encoder sits today, for consumers that must service all pending requests, not just the winner.

## Interface
- W, default 32: request vector width; any value ≥ 2 (not restricted to powers of two).
- IW, default $clog2(W): index width (derived, not overridden).
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous and active-high.
- in  input  W  request vector.
- in_msb_first  input  1  priority mode, sampled with `in`: 0 = lowest index first, 1 = highest index first.
- in_valid  input  1  `in` / `in_msb_first` valid.
- in_ready  output  1  block can accept a vector this cycle.
- out  output  IW  index of the current highest-priority pending bit.
- out_cnt  output  IW+1  number of pending bits, including the current one.
- out_last  output  1  current beat is the final bit of the vector.
- out_valid  output  1  out / out_cnt / out_last valid.
- out_ready  input  1  consumer accepts the beat.
- zero  output  1  one-cycle pulse: an all-zero vector was accepted and dropped.

## Operation
- Internal registers: vec[W-1:0] (pending bits), mode (latched in_msb_first), state ∈ {IDLE, SCAN}.
- All outputs derive from registers only. There is no combinational path from in/in_valid/out_ready to out, out_cnt, out_last or out_valid.
- out = index of the lowest set bit of vec (mode=0) or the highest set bit (mode=1). out_cnt = popcount(vec). out_last = (out_cnt == 1).
- out_valid = (state == SCAN).
- in_ready = !rst && (state == IDLE || (out_valid && out_ready && out_last)).
- Accept (in_valid && in_ready):
  - in ≠ 0: load vec ← in and mode ← in_msb_first; next state SCAN.
  - in = 0: vec is not loaded; next state IDLE; zero = 1 next cycle.
- Beat transfer (out_valid && out_ready): clear bit `out` in vec.
  - If out_last and no accept occurs in the same cycle: next state IDLE.
  - If out_last and an accept occurs in the same cycle: the accept wins and the new vector loads (back-to-back, no bubble).
- out_valid && !out_ready: vec and mode hold, so all out fields stay stable.
- Reset (any cycle, including mid-SCAN): vec ← 0, mode ← 0, state ← IDLE, zero ← 0. Pending bits are discarded, not flushed.
- Reset values:
  - out_valid = 0, out = 0, out_cnt = 0, out_last = 0, zero = 0.
  - in_ready = 0 while rst = 1; in_ready = 1 on the first cycle after release.

## Timing
- Accept at edge N → first beat has out_valid = 1 in cycle N+1.
- With out_ready held at 1, a vector of k set bits yields k beats on cycles N+1 … N+k.
- in_ready is high in cycle N+k, so the next vector's first beat appears in cycle N+k+1.
- Zero vector accepted at edge N → zero = 1 during cycle N+1 only; in_ready stays 1 throughout.
- Throughput: one index per clock. There is no latency dependence on W beyond the combinational priority and popcount depth.
- in_valid may drop or change freely while in_ready = 0. The block does not sample it then.

## Test plan
- Reset: hold rst = 1 for 2 cycles with in_valid = 1 → in_ready = 0, out_valid = 0, out = 0, out_cnt = 0, zero = 0; in_ready = 1 on the first cycle after release.
- LSB-first, W=32: in = 0x0000_0209, in_msb_first = 0, out_ready = 1 → beats out = 0, 3, 9 on consecutive cycles; out_cnt = 3, 2, 1; out_last only on 9; in_ready = 1 in the cycle with 9.
- MSB-first and back-to-back: same vector with in_msb_first = 1 → out = 9, 3, 0. Then in = 0x8000_0000 (msb_first = 0) is presented and held valid → accepted in the cycle of beat 0; out = 31 on the very next cycle, with no bubble.
- Backpressure: in = 0x8000_0001, out_ready = 0 for 3 cycles → out = 0, out_cnt = 2, out_last = 0 stable for all 3 cycles; then out_ready = 1 → beats 0, then 31 with out_last = 1.
- Zero vector: in = 0 → no out_valid; zero = 1 for exactly one cycle; in_ready stays 1; the following in = 0x10 yields out = 4 with out_last = 1.
- Reset mid-operation: in = 0xFFFF_FFFF, LSB-first; assert rst after beats 0–4 → out_valid = 0 next cycle. After release, in = 0x2 yields a single beat out = 1, out_cnt = 1, with no residue from the old vector.
